// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg: shared encodings for the MEM stage (branch, access width, MemtoReg, FSM)
package mem_access_stage_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_BEQ  = 3'b001,
        BR_BNE  = 3'b010,
        BR_BGEZ = 3'b011,
        BR_BGTZ = 3'b100,
        BR_BLEZ = 3'b101,
        BR_BLTZ = 3'b110,
        BR_JUMP = 3'b111
    } branch_e;

    // Codes 101-111 are not listed and behave as a full word access
    typedef enum logic [2:0] {
        EXT_W  = 3'b000,
        EXT_BS = 3'b001,
        EXT_BU = 3'b010,
        EXT_HS = 3'b011,
        EXT_HU = 3'b100
    } ext_e;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_NPC = 2'b10;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_e;

endpackage

// File: rtl/mem_access_stage_load_align.sv
// mem_access_stage_load_align: picks the addressed byte/half of a read word and extends it
module mem_access_stage_load_align
    import mem_access_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  a,
    input  logic [2:0]  ext,
    output logic [31:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    assign b = rdata[{a, 3'b000} +: 8];
    assign h = a[1] ? rdata[31:16] : rdata[15:0];

    // Extend the selected lane according to the access width/signedness
    always_comb begin
        case (ext_e'(ext))
            EXT_BS:  data = {{24{b[7]}}, b};
            EXT_BU:  data = {24'h0, b};
            EXT_HS:  data = {{16{h[15]}}, h};
            EXT_HU:  data = {16'h0, h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MIPS MEM stage with data-bus handshake, stall, load alignment and branch resolve
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Mem_branch_addr,
    input  logic [31:0] Mem_npc,
    input  logic [31:0] Mem_ALUout,
    input  logic [31:0] Mem_datain,
    input  logic [4:0]  Mem_Rw,
    input  logic        Mem_MemWr,
    input  logic [2:0]  Mem_Branch,
    input  logic        Mem_Zero,
    input  logic        Mem_Sign,
    input  logic [2:0]  Mem_ExtOp3,
    input  logic [1:0]  Mem_MemtoReg,
    input  logic        Mem_RegWr,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_be,
    input  logic        dbus_ready,
    input  logic [31:0] dbus_rdata,
    output logic        mem_stall,
    output logic        PCSrc,
    output logic [31:0] branch_target,
    output logic        misalign,
    output logic        bus_err,
    output logic [31:0] Wr_ALUout,
    output logic [31:0] Wr_Dout,
    output logic [31:0] Wr_npc,
    output logic [4:0]  Wr_Rw,
    output logic [1:0]  Wr_MemtoReg,
    output logic        Wr_RegWr
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_e        state;
    logic [CW-1:0] cnt;
    logic          byte_op, half_op, mem_op, misal, go, at_limit, abort, taken;
    logic [31:0]   load_data;

    assign byte_op  = Mem_ExtOp3 == EXT_BS || Mem_ExtOp3 == EXT_BU;
    assign half_op  = Mem_ExtOp3 == EXT_HS || Mem_ExtOp3 == EXT_HU;
    assign mem_op   = Mem_MemWr || Mem_MemtoReg == M2R_MEM;
    assign misal    = mem_op && (half_op ? Mem_ALUout[0] : !byte_op && Mem_ALUout[1:0] != 2'b00);
    assign go       = mem_op && !misal;
    assign at_limit = cnt == CW'(TIMEOUT);
    assign abort    = state == S_WAIT && !dbus_ready && at_limit;

    // Bus and stall controls are gated by rst so they fall the instant reset asserts
    assign dbus_req   = rst && (state == S_WAIT || go);
    assign dbus_we    = dbus_req && Mem_MemWr;
    assign mem_stall  = rst && !dbus_ready && (state == S_WAIT ? !at_limit : go);
    assign dbus_addr  = {Mem_ALUout[31:2], 2'b00};
    assign dbus_be    = byte_op ? 4'b0001 << Mem_ALUout[1:0] :
                        half_op ? (Mem_ALUout[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign dbus_wdata = byte_op ? {4{Mem_datain[7:0]}} :
                        half_op ? {2{Mem_datain[15:0]}} : Mem_datain;

    assign branch_target = Mem_branch_addr;

    mem_access_stage_load_align u_align (
        .rdata (dbus_rdata),
        .a     (Mem_ALUout[1:0]),
        .ext   (Mem_ExtOp3),
        .data  (load_data)
    );

    // Branch condition from the ALU flags
    always_comb begin
        case (branch_e'(Mem_Branch))
            BR_BEQ:  taken = Mem_Zero;
            BR_BNE:  taken = !Mem_Zero;
            BR_BGEZ: taken = !Mem_Sign;
            BR_BGTZ: taken = !Mem_Sign && !Mem_Zero;
            BR_BLEZ: taken = Mem_Sign || Mem_Zero;
            BR_BLTZ: taken = Mem_Sign;
            BR_JUMP: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    assign PCSrc = taken && !misalign && !bus_err;

    // Access FSM, timeout counter and MEM/WB register, all on the pipeline's falling edge
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            misalign    <= 1'b0;
            bus_err     <= 1'b0;
            Wr_ALUout   <= '0;
            Wr_Dout     <= '0;
            Wr_npc      <= '0;
            Wr_Rw       <= '0;
            Wr_MemtoReg <= '0;
            Wr_RegWr    <= 1'b0;
        end else begin
            misalign    <= state == S_IDLE && misal;
            bus_err     <= abort;
            Wr_ALUout   <= Mem_ALUout;
            Wr_Dout     <= load_data;
            Wr_npc      <= Mem_npc;
            Wr_Rw       <= Mem_Rw;
            Wr_MemtoReg <= mem_stall ? M2R_ALU : Mem_MemtoReg;
            Wr_RegWr    <= Mem_RegWr && !mem_stall && !misal && !abort;
            if (state == S_IDLE) begin
                if (go && !dbus_ready) begin
                    state <= S_WAIT;
                    cnt   <= CW'(1);
                end
            end else if (dbus_ready || abort) begin
                state <= S_IDLE;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: randomized and directed checks of the MEM stage against a cycle-level model
module tb_mem_access_stage;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Mem_branch_addr, Mem_npc, Mem_ALUout, Mem_datain;
    logic [4:0]  Mem_Rw;
    logic        Mem_MemWr, Mem_Zero, Mem_Sign, Mem_RegWr;
    logic [2:0]  Mem_Branch, Mem_ExtOp3;
    logic [1:0]  Mem_MemtoReg;
    logic        dbus_req, dbus_we, dbus_ready;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic [3:0]  dbus_be;
    logic        mem_stall, PCSrc, misalign, bus_err;
    logic [31:0] branch_target, Wr_ALUout, Wr_Dout, Wr_npc;
    logic [4:0]  Wr_Rw;
    logic [1:0]  Wr_MemtoReg;
    logic        Wr_RegWr;

    int checks   = 0;
    int failures = 0;
    logic last_exc = 1'b0;

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .Mem_branch_addr(Mem_branch_addr), .Mem_npc(Mem_npc), .Mem_ALUout(Mem_ALUout),
        .Mem_datain(Mem_datain), .Mem_Rw(Mem_Rw), .Mem_MemWr(Mem_MemWr), .Mem_Branch(Mem_Branch),
        .Mem_Zero(Mem_Zero), .Mem_Sign(Mem_Sign), .Mem_ExtOp3(Mem_ExtOp3),
        .Mem_MemtoReg(Mem_MemtoReg), .Mem_RegWr(Mem_RegWr),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
        .dbus_be(dbus_be), .dbus_ready(dbus_ready), .dbus_rdata(dbus_rdata),
        .mem_stall(mem_stall), .PCSrc(PCSrc), .branch_target(branch_target),
        .misalign(misalign), .bus_err(bus_err),
        .Wr_ALUout(Wr_ALUout), .Wr_Dout(Wr_Dout), .Wr_npc(Wr_npc), .Wr_Rw(Wr_Rw),
        .Wr_MemtoReg(Wr_MemtoReg), .Wr_RegWr(Wr_RegWr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic br_taken(input logic [2:0] br, input logic z, input logic s);
        case (br)
            3'd0:    return 1'b0;
            3'd1:    return z;
            3'd2:    return !z;
            3'd3:    return !s;
            3'd4:    return !s && !z;
            3'd5:    return s || z;
            3'd6:    return s;
            default: return 1'b1;
        endcase
    endfunction

    task automatic drive_nop();
        Mem_ALUout = 32'h0; Mem_MemWr = 1'b0; Mem_MemtoReg = 2'b00; Mem_ExtOp3 = 3'd0;
        Mem_RegWr = 1'b0; Mem_Branch = 3'd0; Mem_Zero = 1'b0; Mem_Sign = 1'b0;
        Mem_datain = 32'h0; Mem_Rw = 5'd0; Mem_npc = 32'h0; Mem_branch_addr = 32'h0;
        dbus_ready = 1'b0; dbus_rdata = 32'h0;
    endtask

    // One MEM-stage instruction, from entry until it leaves (completion, exception or bubble end).
    // waitc = number of cycles the bus holds off before ready; anything > TO never answers.
    task automatic do_op(input logic [31:0] a, input logic wr, input logic [2:0] ext,
                         input logic [1:0] m2r, input logic rw, input logic [31:0] wd,
                         input logic [31:0] rd, input int waitc,
                         input logic [2:0] br, input logic z, input logic s);
        logic        mem, mis, bsz, hsz, acc, rdy, stl, ab;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] exp_d, exp_wd, npc, tgt;
        logic [3:0]  exp_be;
        logic [4:0]  rwn;
        int c;
        bsz = ext == 3'd1 || ext == 3'd2;
        hsz = ext == 3'd3 || ext == 3'd4;
        mem = wr || m2r == 2'b01;
        mis = mem && (hsz ? a[0] : !bsz && a[1:0] != 2'b00);
        acc = mem && !mis;
        b = 8'(rd >> (8 * a[1:0]));
        h = 16'(rd >> (16 * a[1]));
        exp_d = ext == 3'd1 ? 32'($signed(b)) : ext == 3'd2 ? 32'(b) :
                ext == 3'd3 ? 32'($signed(h)) : ext == 3'd4 ? 32'(h) : rd;
        exp_be = bsz ? 4'(1 << a[1:0]) : hsz ? (a[1] ? 4'hC : 4'h3) : 4'hF;
        exp_wd = bsz ? {24'h0, wd[7:0]} * 32'h0101_0101 :
                 hsz ? {16'h0, wd[15:0]} * 32'h0001_0001 : wd;
        npc = $urandom; tgt = $urandom; rwn = 5'($urandom);
        Mem_ALUout = a; Mem_MemWr = wr; Mem_ExtOp3 = ext; Mem_MemtoReg = m2r; Mem_RegWr = rw;
        Mem_datain = wd; Mem_Branch = br; Mem_Zero = z; Mem_Sign = s;
        Mem_npc = npc; Mem_branch_addr = tgt; Mem_Rw = rwn;
        c = 0;
        forever begin
            rdy = acc && c == waitc;
            dbus_ready = acc ? rdy : 1'($urandom);
            dbus_rdata = rdy ? rd : $urandom;
            stl = acc && !rdy && c != TO;
            @(posedge clk);
            chk("req", dbus_req, acc);
            chk("stall", mem_stall, stl);
            if (acc) begin
                chk("we", dbus_we, wr);
                chk("addr", dbus_addr, {a[31:2], 2'b00});
                if (wr) begin
                    chk("be", dbus_be, exp_be);
                    chk("wdata", dbus_wdata, exp_wd);
                end
            end
            if (c == 0) begin
                chk("pcsrc", PCSrc, br_taken(br, z, s) && !last_exc);
                chk("target", branch_target, tgt);
            end
            @(negedge clk); #1;
            if (stl) begin
                chk("bubble_regwr", Wr_RegWr, 1'b0);
                chk("bubble_m2r", Wr_MemtoReg, 2'b00);
                chk("bubble_buserr", bus_err, 1'b0);
            end else begin
                ab = acc && !rdy;
                chk("regwr", Wr_RegWr, rw && !mis && !ab);
                chk("m2r", Wr_MemtoReg, m2r);
                chk("aluout", Wr_ALUout, a);
                chk("npc", Wr_npc, npc);
                chk("rw", Wr_Rw, rwn);
                chk("misalign", misalign, mis);
                chk("bus_err", bus_err, ab);
                if (rdy && !wr) chk("dout", Wr_Dout, exp_d);
                last_exc = mis || ab;
                break;
            end
            c++;
        end
        dbus_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        drive_nop();
        Mem_ALUout = 32'h104; Mem_MemtoReg = 2'b01; Mem_RegWr = 1'b1; Mem_Rw = 5'd3;
        #2;
        chk("rst_req", dbus_req, 1'b0);
        chk("rst_stall", mem_stall, 1'b0);
        chk("rst_regwr", Wr_RegWr, 1'b0);
        chk("rst_aluout", Wr_ALUout, 32'h0);
        chk("rst_misalign", misalign, 1'b0);
        chk("rst_buserr", bus_err, 1'b0);
        drive_nop();
        @(posedge clk); rst = 1'b1;
        @(negedge clk); #1;

        do_op(32'h103, 1'b0, 3'd1, 2'b01, 1'b1, 32'h0, 32'h80FF_1234, 0, 3'd0, 1'b0, 1'b0);
        chk("lb_dout", Wr_Dout, 32'hFFFF_FF80);
        do_op(32'h102, 1'b0, 3'd4, 2'b01, 1'b1, 32'h0, 32'h80FF_5678, 3, 3'd0, 1'b0, 1'b0);
        chk("lhu_dout", Wr_Dout, 32'h0000_80FF);
        do_op(32'h201, 1'b1, 3'd1, 2'b00, 1'b0, 32'h0000_00AB, 32'h0, 0, 3'd2, 1'b0, 1'b0);
        do_op(32'h102, 1'b0, 3'd0, 2'b01, 1'b1, 32'h0, 32'h0, 0, 3'd0, 1'b0, 1'b0);
        do_op(32'h0, 1'b0, 3'd0, 2'b00, 1'b1, 32'h0, 32'h0, 0, 3'd7, 1'b0, 1'b0);
        do_op(32'h104, 1'b0, 3'd0, 2'b01, 1'b1, 32'h0, 32'h0, 100, 3'd0, 1'b0, 1'b0);
        do_op(32'h0, 1'b0, 3'd0, 2'b00, 1'b1, 32'h0, 32'h0, 0, 3'd7, 1'b0, 1'b0);
        do_op(32'h0, 1'b0, 3'd0, 2'b00, 1'b1, 32'h0, 32'h0, 0, 3'd7, 1'b0, 1'b0);

        // Reset while the bus is stalling in its second wait cycle
        Mem_ALUout = 32'h300; Mem_MemtoReg = 2'b01; Mem_RegWr = 1'b1; Mem_ExtOp3 = 3'd0;
        Mem_Branch = 3'd0; dbus_ready = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); #1; end
        @(posedge clk);
        chk("pre_rst_stall", mem_stall, 1'b1);
        rst = 1'b0;
        #1;
        chk("mid_rst_req", dbus_req, 1'b0);
        chk("mid_rst_stall", mem_stall, 1'b0);
        chk("mid_rst_aluout", Wr_ALUout, 32'h0);
        chk("mid_rst_m2r", Wr_MemtoReg, 2'b00);
        drive_nop();
        @(posedge clk); rst = 1'b1;
        @(negedge clk); #1;
        chk("post_rst_buserr", bus_err, 1'b0);
        chk("post_rst_req", dbus_req, 1'b0);
        last_exc = 1'b0;

        for (int i = 0; i < 80; i++) begin
            logic       wr;
            logic [1:0] m2r;
            int         wt;
            wr  = $urandom_range(0, 3) == 0;
            m2r = wr ? 2'b00 : 2'($urandom_range(0, 2));
            wt  = $urandom_range(0, 7) == 0 ? 40 : $urandom_range(0, 4);
            do_op($urandom, wr, 3'($urandom), m2r, wr ? 1'b0 : 1'($urandom), $urandom, $urandom,
                  wt, 3'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
